// File: rtl/buzzer_seq.sv
// Prioritised buzzer sequencer: latches CLICK/STOP/WIN requests and plays
// N on/off beeps for the granted owner; WIN may preempt CLICK or STOP.
module buzzer_seq #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned ON_TICKS  = 100,
  parameter int unsigned OFF_TICKS = 100,
  parameter int unsigned N_CLICK   = 1,
  parameter int unsigned N_STOP    = 2,
  parameter int unsigned N_WIN     = 5
) (
  input  logic       CK,
  input  logic       RB,
  input  logic [2:0] REQ,
  output logic       EN_BUZZER,
  output logic [2:0] GNT,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_e;

  localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  ON_LAST  = 8'(ON_TICKS - 1);
  localparam logic [7:0]  OFF_LAST = 8'(OFF_TICKS - 1);
  localparam logic [3:0]  NB_CLICK = 4'(N_CLICK);
  localparam logic [3:0]  NB_STOP  = 4'(N_STOP);
  localparam logic [3:0]  NB_WIN   = 4'(N_WIN);

  state_e      state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [3:0]  beep_q, beep_d;
  logic [15:0] pre_q, pre_d;
  logic [7:0]  tick_q, tick_d;
  logic        done_q, done_d;

  logic [2:0]  pend_all;
  logic [2:0]  sel;
  logic        win_pre;
  logic        grant;
  logic        phase_end;

  always_ff @(posedge CK or posedge RB) begin
    if (RB) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      gnt_q   <= '0;
      beep_q  <= '0;
      pre_q   <= '0;
      tick_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      beep_q  <= beep_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  // Requests arriving this edge participate in arbitration immediately.
  always_comb begin
    pend_all = pend_q | REQ;
    win_pre  = (state_q != S_IDLE) && !gnt_q[2] && pend_all[2];
    grant    = ((state_q == S_IDLE) && (pend_all != 3'b000)) || win_pre;
    if (pend_all[2])      sel = 3'b100;
    else if (pend_all[1]) sel = 3'b010;
    else                  sel = 3'b001;
    phase_end = 1'b0;
    if (pre_q == PRE_LAST) begin
      if (state_q == S_ON)       phase_end = (tick_q == ON_LAST);
      else if (state_q == S_OFF) phase_end = (tick_q == OFF_LAST);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (grant) state_d = S_ON;
      S_ON: begin
        if (win_pre)        state_d = S_ON;
        else if (phase_end) state_d = S_OFF;
      end
      S_OFF: begin
        if (win_pre)        state_d = S_ON;
        else if (phase_end) state_d = (beep_q != 4'd0) ? S_ON : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pend_d = pend_all;
    gnt_d  = gnt_q;
    beep_d = beep_q;
    done_d = 1'b0;
    pre_d  = '0;
    tick_d = '0;
    if (grant) begin
      gnt_d  = sel;
      // A preempted owner's re-request is discarded along with its pattern.
      pend_d = win_pre ? (pend_all & ~sel & ~gnt_q) : (pend_all & ~sel);
      unique case (sel)
        3'b100:  beep_d = NB_WIN;
        3'b010:  beep_d = NB_STOP;
        default: beep_d = NB_CLICK;
      endcase
    end else if (phase_end) begin
      if (state_q == S_ON) begin
        beep_d = beep_q - 4'd1;
      end else if (beep_q == 4'd0) begin
        gnt_d  = '0;
        done_d = 1'b1;
      end
    end else if (state_q != S_IDLE) begin
      if (pre_q == PRE_LAST) begin
        tick_d = tick_q + 8'd1;
      end else begin
        pre_d  = pre_q + 16'd1;
        tick_d = tick_q;
      end
    end
  end

  always_comb begin
    EN_BUZZER = (state_q == S_ON);
    BUSY      = (state_q != S_IDLE);
    GNT       = gnt_q;
    DONE      = done_q;
  end

endmodule
